// File: rtl/csr_reg_responder_if.sv
// Bus2Reg request channel between the APB slave (master side) and the register responder.
interface csr_reg_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
);
    logic                  bus_req;
    logic                  bus_req_is_wr;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wr_data;
    logic [DATA_WIDTH-1:0] bus_wr_biten;
    logic                  bus_req_stall_wr;
    logic                  bus_req_stall_rd;
    logic                  bus_ready;
    logic                  bus_err;
    logic [DATA_WIDTH-1:0] bus_rd_data;

    modport master (
        output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        output bus_req_stall_wr, bus_req_stall_rd,
        input  bus_ready, bus_err, bus_rd_data
    );

    modport slave (
        input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        input  bus_req_stall_wr, bus_req_stall_rd,
        output bus_ready, bus_err, bus_rd_data
    );
endinterface

// File: rtl/csr_reg_responder.sv
// Register-map responder: NUM_RW read/write control registers plus one read-only
// status word, answering each Bus2Reg request with a single-cycle ready pulse.
module csr_reg_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    NUM_RW     = 8,
    parameter int                    RD_WAIT    = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    csr_reg_responder_if.slave           bus,
    input  logic [DATA_WIDTH-1:0]        hw_status,
    output logic [NUM_RW*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_RW-1:0]            reg_wr_pulse
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam logic [IW-1:0] STAT_IDX = IW'(NUM_RW);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt, cnt_load;
    logic                  cap_en, complete, stall;

    logic                  cap_wr;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_data, cap_biten;

    logic                  cur_wr;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data, cur_biten;

    logic [IW-1:0]         idx;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] regs [NUM_RW];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The accepting edge in IDLE already counts as one unstalled wait cycle,
    // so PEND is entered with the remaining count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_en    = 1'b0;
        complete  = 1'b0;
        stall     = 1'b0;
        cnt_load  = '0;
        cur_wr    = cap_wr;
        cur_addr  = cap_addr;
        cur_data  = cap_data;
        cur_biten = cap_biten;
        case (state)
            IDLE: begin
                if (bus.bus_req) begin
                    cap_en    = 1'b1;
                    cur_wr    = bus.bus_req_is_wr;
                    cur_addr  = bus.bus_addr;
                    cur_data  = bus.bus_wr_data;
                    cur_biten = bus.bus_wr_biten;
                    stall     = bus.bus_req_is_wr ? bus.bus_req_stall_wr : bus.bus_req_stall_rd;
                    cnt_load  = bus.bus_req_is_wr ? 4'd0 : 4'(RD_WAIT);
                    if (!stall && cnt_load == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        state_nxt = PEND;
                        cnt_nxt   = stall ? cnt_load : cnt_load - 4'd1;
                    end
                end
            end
            PEND: begin
                stall = cap_wr ? bus.bus_req_stall_wr : bus.bus_req_stall_rd;
                if (!stall) begin
                    if (cnt != 4'd0) begin
                        cnt_nxt = cnt - 4'd1;
                    end else begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx     = cur_addr[ADDR_WIDTH-1:2];
        dec_err = (cur_addr[1:0] != 2'b00) || (idx > STAT_IDX) || (cur_wr && idx == STAT_IDX);
    end

    always_comb begin
        rd_val = '0;
        if (idx == STAT_IDX) begin
            rd_val = hw_status;
        end else begin
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                if (idx == IW'(i)) rd_val = regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_wr           <= 1'b0;
            cap_addr         <= '0;
            cap_data         <= '0;
            cap_biten        <= '0;
            bus.bus_ready    <= 1'b0;
            bus.bus_err      <= 1'b0;
            bus.bus_rd_data  <= '0;
            reg_wr_pulse     <= '0;
            for (int unsigned i = 0; i < NUM_RW; i++) regs[i] <= RESET_VAL;
        end else begin
            if (cap_en) begin
                cap_wr    <= bus.bus_req_is_wr;
                cap_addr  <= bus.bus_addr;
                cap_data  <= bus.bus_wr_data;
                cap_biten <= bus.bus_wr_biten;
            end
            bus.bus_ready   <= complete;
            bus.bus_err     <= complete && dec_err;
            bus.bus_rd_data <= (complete && !cur_wr && !dec_err) ? rd_val : '0;
            reg_wr_pulse    <= '0;
            if (complete && cur_wr && !dec_err) begin
                for (int unsigned i = 0; i < NUM_RW; i++) begin
                    if (idx == IW'(i)) begin
                        regs[i]         <= (regs[i] & ~cur_biten) | (cur_data & cur_biten);
                        reg_wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < NUM_RW; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

endmodule
